demux4_stream: RTL and testbench
================================

Name: demux4_stream

Overview:
- 1-to-4 demultiplexer: the distribution-side counterpart of the team's 4:1 mux.
- Accepts one data word per handshake on a single input stream.
- Routes the word to the output channel chosen by a 2-bit select, or to all four channels in broadcast mode.
- Each output channel has a one-entry registered holding stage with a valid/ready handshake, so a stalled channel blocks only traffic addressed to it.

Parameters:
- DATA_W, 8, width of the data word on the input and on each output channel.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1.
- in_bcast  input  1  deliver the word to all four channels.
- in_data  input  DATA_W  input word.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: downstream of channel i takes the word.
- out_data0..out_data3  output  DATA_W each  held word of channels 0..3.
- acc_cnt  output  16  count of accepted input handshakes.

Behaviour:
- Reset, synchronous, at the rising edge with rst=1:
  - out_valid=4'b0000, out_data0..3=0, acc_cnt=0.
  - Any held words are discarded.
  - in_ready is forced to 0 combinationally while rst=1, so no transfer is accepted in a reset cycle.
- Channel free condition: free[i] = !out_valid[i] || out_ready[i]. A channel being drained in the same cycle counts as free.
- Input ready (combinational from registered state and out_ready):
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = &free.
  - There is no in_valid to in_ready dependency.
- Accept = in_valid && in_ready. Load targets:
  - Unicast: channel in_sel only.
  - Broadcast: all four channels.
- Per-channel update at each edge, in priority order:
  - Loaded: out_data_i <= in_data, out_valid[i] <= 1. This covers simultaneous drain+load; the new word replaces the drained one with no bubble.
  - Not loaded, out_valid[i] && out_ready[i]: out_valid[i] <= 0, out_data_i holds its last value.
  - Otherwise: hold.
- Latency: a word accepted at edge N is visible on out_valid/out_data at edge N (registered), one cycle after presentation. Sustained throughput is 1 word/cycle per channel when out_ready stays high.
- Unaddressed channels are never disturbed by a unicast load.
- Broadcast is all-or-nothing: there is no partial delivery. If any channel is not free, nothing is accepted and nothing is loaded.
- acc_cnt increments by 1 per accept, including broadcast (counts 1, not 4). It wraps 16'hFFFF -> 16'h0000 with no flag.
- Inputs with in_valid=0 are ignored. in_sel, in_bcast and in_data may change freely while in_valid=0.
- in_valid may be deasserted without being accepted; there is no stickiness requirement on the source.
- out_valid[i] must not drop without an out_ready[i] handshake, except by reset.
- out_data_i must be stable while out_valid[i]=1 and out_ready[i]=0.

Test Plan:
- Unicast round-robin: after reset, out_ready=4'b1111; send 8'hA0..8'hA3 with in_sel=0..3 on consecutive cycles.
  - Each out_valid[i] pulses for 1 cycle with out_dataI=8'hA0+i, one cycle after its accept.
  - in_ready stays 1 throughout; acc_cnt=4.
- Backpressure isolation: out_ready=4'b1101; send 8'h11 to ch1, then 8'h22 to ch1, then 8'h33 to ch2.
  - 8'h11 is held in ch1; in_ready=0 for the second ch1 word.
  - 8'h33 is accepted and appears on ch2 with ch1 unchanged.
  - Raising out_ready[1] drains 8'h11, and 8'h22 is accepted in that same cycle.
- Broadcast: out_ready=4'b0111 with ch3 holding 8'h5A; send in_bcast=1, in_data=8'hC3.
  - in_ready=0 and no channel loads.
  - Set out_ready[3]=1: accept occurs, all four channels hold 8'hC3 next cycle, acc_cnt +1.
- Simultaneous drain+load: ch0 holds 8'h01 with out_ready[0]=1; present 8'h02 to ch0 every cycle.
  - out_valid[0] stays 1 continuously, data sequence 01, 02, ... with no bubble.
- Reset mid-operation: three channels held, in_valid=1; assert rst for 1 cycle.
  - in_ready=0 during rst.
  - Next cycle out_valid=0, all out_data=0, acc_cnt=0; normal traffic resumes the cycle after rst drops.
- Counter wrap: drive 65536 unicast accepts with out_ready=4'b1111 -> acc_cnt returns to 16'h0000.

Source files
------------

// File: rtl/demux4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one input stream, four
// output channels with valid/ready, and the accept counter.
interface demux4_stream_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_sel;
   logic              in_bcast;
   logic [DATA_W-1:0] in_data;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic [DATA_W-1:0] out_data0;
   logic [DATA_W-1:0] out_data1;
   logic [DATA_W-1:0] out_data2;
   logic [DATA_W-1:0] out_data3;
   logic [15:0]       acc_cnt;

   // The surrounding environment: it feeds the input stream and sinks the channels.
   modport master (
      output in_valid, in_sel, in_bcast, in_data, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, acc_cnt
   );

   modport slave (
      input  in_valid, in_sel, in_bcast, in_data, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, acc_cnt
   );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer with a one-entry holding register per channel,
// unicast or all-or-nothing broadcast delivery, and a wrapping accept counter.
module demux4_stream #(
   parameter int DATA_W = 8
) (
   input logic             clk,
   input logic             rst,
   demux4_stream_if.slave  bus
);

   logic [3:0]        valid_q;
   logic [DATA_W-1:0] data_q [4];
   logic [15:0]       cnt_q;

   logic [3:0] free;
   logic [3:0] target;
   logic [3:0] load;
   logic       accept;

   // A transfer is possible only when every channel it targets is empty or
   // being drained this cycle, so broadcast never delivers partially.
   always_comb begin
      free         = ~valid_q | bus.out_ready;
      target       = bus.in_bcast ? 4'b1111 : (4'b0001 << bus.in_sel);
      bus.in_ready = !rst && ((free & target) == target);
      accept       = bus.in_valid && bus.in_ready;
      load         = accept ? target : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 4'b0000;
         cnt_q   <= 16'h0000;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         // A load wins over a drain so a back-to-back word causes no bubble.
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               data_q[i]  <= bus.in_data;
               valid_q[i] <= 1'b1;
            end else if (valid_q[i] && bus.out_ready[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
         if (accept) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data0 = data_q[0];
   assign bus.out_data1 = data_q[1];
   assign bus.out_data2 = data_q[2];
   assign bus.out_data3 = data_q[3];
   assign bus.acc_cnt   = cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vector table, hand-written
// reset and counter-wrap sequences, and random traffic against a slot model.
module tb_demux4_stream;

   logic clk = 1'b0;
   logic rst;

   demux4_stream_if #(.DATA_W(8)) bus();

   demux4_stream #(.DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: slot[i] is the word waiting in channel i or -1 when empty,
   // shown[i] is what the channel's data output presents.
   int slot [4];
   int shown [4];
   int accCount;

   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic        bc;
      logic [7:0]  d;
      logic [3:0]  rdy;
      logic        expRdy;
      logic [3:0]  expValid;
      logic [15:0] expCnt;
      logic [7:0]  expData;
   } vec_t;

   vec_t tbl [18];

   task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] outData(input int i);
      case (i)
         0:       return bus.out_data0;
         1:       return bus.out_data1;
         2:       return bus.out_data2;
         default: return bus.out_data3;
      endcase
   endfunction

   function automatic logic modelReady();
      if (rst) return 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((bus.in_bcast || int'(bus.in_sel) == i) && slot[i] >= 0 && !bus.out_ready[i])
            return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic modelEdge();
      logic acc;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            slot[i]  = -1;
            shown[i] = 0;
         end
         accCount = 0;
      end else begin
         acc = bus.in_valid && modelReady();
         for (int i = 0; i < 4; i++) begin
            if (acc && (bus.in_bcast || int'(bus.in_sel) == i)) begin
               slot[i]  = int'(bus.in_data);
               shown[i] = int'(bus.in_data);
            end else if (slot[i] >= 0 && bus.out_ready[i]) begin
               slot[i] = -1;
            end
         end
         if (acc) accCount = (accCount + 1) % 65536;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic bc,
                                input logic [7:0] d, input logic [3:0] rdy);
      bus.in_valid  = v;
      bus.in_sel    = sel;
      bus.in_bcast  = bc;
      bus.in_data   = d;
      bus.out_ready = rdy;
   endtask

   task automatic checkReady();
      cmp("in_ready", 32'(bus.in_ready), 32'(modelReady()));
   endtask

   task automatic checkOutput();
      logic [3:0] ev;
      for (int i = 0; i < 4; i++) begin
         ev[i] = (slot[i] >= 0);
         cmp($sformatf("out_data%0d", i), 32'(outData(i)), 32'(shown[i]));
      end
      cmp("out_valid", 32'(bus.out_valid), 32'(ev));
      cmp("acc_cnt", 32'(bus.acc_cnt), 32'(accCount));
   endtask

   // Inputs settle, ready is checked, the model advances, then outputs are checked 1 after the edge.
   task automatic step(input bit doCheck);
      #1;
      if (doCheck) checkReady();
      modelEdge();
      @(posedge clk);
      #1;
      if (doCheck) checkOutput();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         slot[i]  = -1;
         shown[i] = 0;
      end
      accCount = 0;

      $display("[TB] reset");
      rst = 1'b1;
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(1);
      rst = 1'b0;

      // Round robin, backpressure, broadcast, drain+load, all from a fresh reset.
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 16'd1,  8'hA0};
      tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'hA1, 4'b1111, 1'b1, 4'b0010, 16'd2,  8'hA1};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hA2, 4'b1111, 1'b1, 4'b0100, 16'd3,  8'hA2};
      tbl[3]  = '{1'b1, 2'd3, 1'b0, 8'hA3, 4'b1111, 1'b1, 4'b1000, 16'd4,  8'hA3};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 16'd4,  8'hA0};
      tbl[5]  = '{1'b1, 2'd1, 1'b0, 8'h11, 4'b1101, 1'b1, 4'b0010, 16'd5,  8'h11};
      tbl[6]  = '{1'b1, 2'd1, 1'b0, 8'h22, 4'b1101, 1'b0, 4'b0010, 16'd5,  8'h11};
      tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'h33, 4'b1101, 1'b1, 4'b0110, 16'd6,  8'h33};
      tbl[8]  = '{1'b1, 2'd1, 1'b0, 8'h22, 4'b1111, 1'b1, 4'b0010, 16'd7,  8'h22};
      tbl[9]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 16'd7,  8'hA0};
      tbl[10] = '{1'b1, 2'd3, 1'b0, 8'h5A, 4'b0111, 1'b1, 4'b1000, 16'd8,  8'h5A};
      tbl[11] = '{1'b1, 2'd3, 1'b1, 8'hC3, 4'b0111, 1'b0, 4'b1000, 16'd8,  8'h5A};
      tbl[12] = '{1'b1, 2'd3, 1'b1, 8'hC3, 4'b1111, 1'b1, 4'b1111, 16'd9,  8'hC3};
      tbl[13] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 16'd9,  8'hC3};
      tbl[14] = '{1'b1, 2'd0, 1'b0, 8'h01, 4'b1111, 1'b1, 4'b0001, 16'd10, 8'h01};
      tbl[15] = '{1'b1, 2'd0, 1'b0, 8'h02, 4'b1111, 1'b1, 4'b0001, 16'd11, 8'h02};
      tbl[16] = '{1'b1, 2'd0, 1'b0, 8'h03, 4'b1111, 1'b1, 4'b0001, 16'd12, 8'h03};
      tbl[17] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 16'd12, 8'h03};

      $display("[TB] directed vectors");
      for (int n = 0; n < 18; n++) begin
         applyStimulus(tbl[n].v, tbl[n].sel, tbl[n].bc, tbl[n].d, tbl[n].rdy);
         #1;
         cmp($sformatf("vec%0d_ready", n), 32'(bus.in_ready), 32'(tbl[n].expRdy));
         checkReady();
         modelEdge();
         @(posedge clk);
         #1;
         cmp($sformatf("vec%0d_valid", n), 32'(bus.out_valid), 32'(tbl[n].expValid));
         cmp($sformatf("vec%0d_cnt", n), 32'(bus.acc_cnt), 32'(tbl[n].expCnt));
         cmp($sformatf("vec%0d_data", n), 32'(outData(int'(tbl[n].sel))), 32'(tbl[n].expData));
         checkOutput();
      end

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 2'd0, 1'b0, 8'h10, 4'b0000);
      step(1);
      applyStimulus(1'b1, 2'd1, 1'b0, 8'h11, 4'b0000);
      step(1);
      applyStimulus(1'b1, 2'd2, 1'b0, 8'h12, 4'b0000);
      step(1);
      cmp("held_three", 32'(bus.out_valid), 32'(4'b0111));
      rst = 1'b1;
      applyStimulus(1'b1, 2'd3, 1'b0, 8'h13, 4'b1111);
      #1;
      cmp("rst_ready", 32'(bus.in_ready), 32'd0);
      modelEdge();
      @(posedge clk);
      #1;
      cmp("rst_valid", 32'(bus.out_valid), 32'd0);
      cmp("rst_cnt", 32'(bus.acc_cnt), 32'd0);
      for (int i = 0; i < 4; i++) cmp($sformatf("rst_data%0d", i), 32'(outData(i)), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 2'd3, 1'b0, 8'hAB, 4'b1111);
      #1;
      cmp("resume_ready", 32'(bus.in_ready), 32'd1);
      modelEdge();
      @(posedge clk);
      #1;
      cmp("resume_valid", 32'(bus.out_valid), 32'(4'b1000));
      cmp("resume_data3", 32'(bus.out_data3), 32'h0000_00AB);
      cmp("resume_cnt", 32'(bus.acc_cnt), 32'd1);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                       4'($urandom_range(0, 15)));
         step(1);
      end
      rst = 1'b0;

      $display("[TB] counter wrap");
      rst = 1'b1;
      applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
      step(1);
      rst = 1'b0;
      for (int n = 0; n < 65535; n++) begin
         applyStimulus(1'b1, 2'(n % 4), 1'b0, 8'(n), 4'b1111);
         step(0);
      end
      cmp("cnt_ffff", 32'(bus.acc_cnt), 32'h0000_FFFF);
      applyStimulus(1'b1, 2'd3, 1'b0, 8'h77, 4'b1111);
      step(1);
      cmp("cnt_wrap", 32'(bus.acc_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
